mc_control_unit_v2: RTL and testbench

Parametrised second-generation multi-cycle control FSM for the MIPS-subset CPU. It drives the datapath strobes and mux selects for IF/ID/EX/MEM/WB. Over the first-generation unit it adds:
- variable-latency memory handshake (mem_ready) on fetch and data access;
- a wait-state timeout;
- BNE and SLT support;
- an illegal-instruction trap;
- a retired-instruction counter.

It sits between the instruction register and the datapath muxes.

---
 rtl/mc_control_unit_v2.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_control_unit_v2.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit_v2.sv
// mc_control_unit_v2: multi-cycle control FSM for the MIPS-subset CPU.
// Drives datapath strobes and mux selects through IF/ID/EX/MEM/WB. It waits
// on a variable-latency memory, times out stalled accesses into ERR, traps or
// skips illegal instructions, and counts retired instructions.
//
// Handshake: memory requests (mem_read / mem_write) are held high for as long
// as the FSM sits in IF or MEM. An access completes on the cycle mem_ready is
// high while the request is up. The FSM takes no other handshake inputs.
module mc_control_unit_v2 #(
  parameter int OPCODE_W     = 6,
  parameter int FUNCT_W      = 6,
  parameter int ALU_OP_W     = 4,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 16,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                ab_write,
  output logic                alu_out_write,
  output logic                mdr_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                retire,
  output logic                err,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_ERR  = 3'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(35);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(43);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(32);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(34);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(36);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(37);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(42);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

  // Wait counter only needs to reach TIMEOUT-1; timeout fires at that value.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] TO_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
  localparam bit TRAP = (ILLEGAL_TRAP != 0);

  state_t              state_q;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    instr_count_q;
  logic                waiting;
  logic                timeout_hit;
  logic                funct_ok;
  logic [ALU_OP_W-1:0] r_alu_op;

  assign state       = state_q;
  assign instr_count = instr_count_q;
  assign err         = (state_q == S_ERR);
  assign waiting     = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && !mem_ready && (wait_cnt == TO_LAST);

  // R-type funct decode to ALU opcode, flagging unknown funct codes.
  always_comb begin
    funct_ok = 1'b1;
    r_alu_op = ALU_ADD;
    case (funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // Per-state strobes, mux selects and next-state selection.
  always_comb begin
    state_nxt     = state_q;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    ir_write      = 1'b0;
    ab_write      = 1'b0;
    alu_out_write = 1'b0;
    mdr_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_op        = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    retire        = 1'b0;
    case (state_q)
      S_INIT: state_nxt = S_IF;
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)        state_nxt = S_ID;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_ID: begin
        // Branch target PC + (imm << 2) is precomputed into ALU-out here.
        ab_write      = 1'b1;
        alu_out_write = 1'b1;
        alu_src_b     = 2'd3;
        case (opcode)
          OP_J: begin
            pc_write  = 1'b1;
            pc_src    = 2'd2;
            retire    = 1'b1;
            state_nxt = S_IF;
          end
          OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_nxt = S_EX;
          default: begin
            retire    = ~TRAP;
            state_nxt = TRAP ? S_ERR : S_IF;
          end
        endcase
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            if (funct_ok) begin
              alu_src_a     = 1'b1;
              alu_op        = r_alu_op;
              alu_out_write = 1'b1;
              state_nxt     = S_WB;
            end else begin
              retire    = ~TRAP;
              state_nxt = TRAP ? S_ERR : S_IF;
            end
          end
          OP_ADDI, OP_LW, OP_SW: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'd2;
            alu_out_write = 1'b1;
            state_nxt     = (opcode == OP_ADDI) ? S_WB : S_MEM;
          end
          OP_ORI: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'd2;
            alu_op        = ALU_OR;
            alu_out_write = 1'b1;
            state_nxt     = S_WB;
          end
          OP_BEQ, OP_BNE: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'd1;
            pc_write  = (opcode == OP_BEQ) ? zero : !zero;
            retire    = 1'b1;
            state_nxt = S_IF;
          end
          default: begin
            retire    = ~TRAP;
            state_nxt = TRAP ? S_ERR : S_IF;
          end
        endcase
      end
      S_MEM: begin
        if (opcode == OP_LW) begin
          mem_read  = 1'b1;
          mdr_write = mem_ready;
          if (mem_ready)        state_nxt = S_WB;
          else if (timeout_hit) state_nxt = S_ERR;
        end else if (opcode == OP_SW) begin
          mem_write = 1'b1;
          retire    = mem_ready;
          if (mem_ready)        state_nxt = S_IF;
          else if (timeout_hit) state_nxt = S_ERR;
        end else begin
          state_nxt = S_IF;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        reg_dst    = (opcode == OP_R);
        mem_to_reg = (opcode == OP_LW);
        state_nxt  = S_IF;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // State register, memory wait counter and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      wait_cnt      <= '0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_nxt != state_q) wait_cnt <= '0;
      else if (waiting)         wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire) instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_unit_v2.sv
// tb_mc_control_unit_v2: directed bench for mc_control_unit_v2.
// Instance a uses default parameters; instance b uses TIMEOUT=4, CNT_W=2 and
// ILLEGAL_TRAP=0. Strobes are grouped as
// {pc_write, ir_write, ab_write, alu_out_write, mdr_write, mem_read,
//  mem_write, reg_write, retire} and selects as
// {pc_src[1:0], reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[3:0]}.
module tb_mc_control_unit_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance a ----------------
  logic       a_rst_n, a_zero, a_mem_ready;
  logic [5:0] a_opcode, a_funct;
  logic [2:0] a_state;
  logic       a_pc_write, a_ir_write, a_ab_write, a_alu_out_write, a_mdr_write;
  logic       a_mem_read, a_mem_write, a_reg_write, a_reg_dst, a_mem_to_reg;
  logic       a_alu_src_a, a_retire, a_err;
  logic [1:0] a_pc_src, a_alu_src_b;
  logic [3:0] a_alu_op;
  logic [31:0] a_instr_count;

  mc_control_unit_v2 dut_a (
    .clk(clk), .rst_n(a_rst_n), .opcode(a_opcode), .funct(a_funct),
    .zero(a_zero), .mem_ready(a_mem_ready), .state(a_state),
    .pc_write(a_pc_write), .pc_src(a_pc_src), .ir_write(a_ir_write),
    .ab_write(a_ab_write), .alu_out_write(a_alu_out_write),
    .mdr_write(a_mdr_write), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .alu_op(a_alu_op), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .retire(a_retire), .err(a_err), .instr_count(a_instr_count)
  );

  wire [8:0]  a_stb = {a_pc_write, a_ir_write, a_ab_write, a_alu_out_write, a_mdr_write,
                       a_mem_read, a_mem_write, a_reg_write, a_retire};
  wire [10:0] a_sel = {a_pc_src, a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_src_b, a_alu_op};

  // ---------------- instance b ----------------
  logic       b_rst_n, b_zero, b_mem_ready;
  logic [5:0] b_opcode, b_funct;
  logic [2:0] b_state;
  logic       b_pc_write, b_ir_write, b_ab_write, b_alu_out_write, b_mdr_write;
  logic       b_mem_read, b_mem_write, b_reg_write, b_reg_dst, b_mem_to_reg;
  logic       b_alu_src_a, b_retire, b_err;
  logic [1:0] b_pc_src, b_alu_src_b;
  logic [3:0] b_alu_op;
  logic [1:0] b_instr_count;

  mc_control_unit_v2 #(.TIMEOUT(4), .CNT_W(2), .ILLEGAL_TRAP(0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .opcode(b_opcode), .funct(b_funct),
    .zero(b_zero), .mem_ready(b_mem_ready), .state(b_state),
    .pc_write(b_pc_write), .pc_src(b_pc_src), .ir_write(b_ir_write),
    .ab_write(b_ab_write), .alu_out_write(b_alu_out_write),
    .mdr_write(b_mdr_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .alu_op(b_alu_op), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .retire(b_retire), .err(b_err), .instr_count(b_instr_count)
  );

  wire [8:0]  b_stb = {b_pc_write, b_ir_write, b_ab_write, b_alu_out_write, b_mdr_write,
                       b_mem_read, b_mem_write, b_reg_write, b_retire};
  wire [10:0] b_sel = {b_pc_src, b_reg_dst, b_mem_to_reg, b_alu_src_a, b_alu_src_b, b_alu_op};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input int st, input logic [8:0] stb, input logic [10:0] sel);
    check({tag, ".state"}, 32'(a_state), 32'(st));
    check({tag, ".stb"},   32'(a_stb),   32'(stb));
    check({tag, ".sel"},   32'(a_sel),   32'(sel));
  endtask

  task automatic check_b(input string tag, input int st, input logic [8:0] stb, input logic [10:0] sel);
    check({tag, ".state"}, 32'(b_state), 32'(st));
    check({tag, ".stb"},   32'(b_stb),   32'(stb));
    check({tag, ".sel"},   32'(b_sel),   32'(sel));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected strobe patterns.
  localparam logic [8:0] STB_NONE   = 9'b000000000;
  localparam logic [8:0] STB_IF_RDY = 9'b110001000;
  localparam logic [8:0] STB_IF_WT  = 9'b000001000;
  localparam logic [8:0] STB_ID     = 9'b001100000;
  localparam logic [8:0] STB_ID_J   = 9'b101100001;
  localparam logic [8:0] STB_ID_ILL = 9'b001100001;
  localparam logic [8:0] STB_EX     = 9'b000100000;
  localparam logic [8:0] STB_BR_TK  = 9'b100000001;
  localparam logic [8:0] STB_BR_NT  = 9'b000000001;
  localparam logic [8:0] STB_LW_WT  = 9'b000001000;
  localparam logic [8:0] STB_LW_RDY = 9'b000011000;
  localparam logic [8:0] STB_SW_WT  = 9'b000000100;
  localparam logic [8:0] STB_WB     = 9'b000000011;

  // Expected select patterns.
  localparam logic [10:0] SEL_ZERO = 11'd0;
  localparam logic [10:0] SEL_IF   = {2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0};
  localparam logic [10:0] SEL_ID   = {2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0};
  localparam logic [10:0] SEL_ID_J = {2'd2, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0};
  localparam logic [10:0] SEL_IMM  = {2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0};
  localparam logic [10:0] SEL_ORI  = {2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd3};
  localparam logic [10:0] SEL_BR   = {2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1};
  localparam logic [10:0] SEL_SLT  = {2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd4};
  localparam logic [10:0] SEL_WB_R = {2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0};
  localparam logic [10:0] SEL_WB_L = {2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0};

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] j_exp [4];
    a_rst_n = 1'b0; a_opcode = 6'd8; a_funct = 6'd0; a_zero = 1'b0; a_mem_ready = 1'b1;
    b_rst_n = 1'b0; b_opcode = 6'd2; b_funct = 6'd0; b_zero = 1'b0; b_mem_ready = 1'b0;
    #3;
    check_a("a_reset", 0, STB_NONE, SEL_ZERO);
    check("a_reset.count", a_instr_count, 32'd0);
    check("a_reset.err", 32'(a_err), 32'd0);

    // ---- ADDI with memory always ready ----
    @(negedge clk);
    a_rst_n = 1'b1;
    #1 check_a("addi_init", 0, STB_NONE, SEL_ZERO);
    tick(); check_a("addi_if", 1, STB_IF_RDY, SEL_IF);
    tick(); check_a("addi_id", 2, STB_ID, SEL_ID);
    tick(); check_a("addi_ex", 3, STB_EX, SEL_IMM);
    tick(); check_a("addi_wb", 5, STB_WB, SEL_ZERO);
    tick(); check("addi_count", a_instr_count, 32'd1);

    // ---- LW with three wait cycles in IF and in MEM ----
    a_opcode = 6'd35; a_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check_a($sformatf("lw_if_wait%0d", i), 1, STB_IF_WT, SEL_IF);
      tick();
    end
    a_mem_ready = 1'b1;
    #1 check_a("lw_if_rdy", 1, STB_IF_RDY, SEL_IF);
    tick(); check_a("lw_id", 2, STB_ID, SEL_ID);
    tick(); check_a("lw_ex", 3, STB_EX, SEL_IMM);
    a_mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1 check_a($sformatf("lw_mem_wait%0d", i), 4, STB_LW_WT, SEL_ZERO);
      tick();
    end
    a_mem_ready = 1'b1;
    #1 check_a("lw_mem_rdy", 4, STB_LW_RDY, SEL_ZERO);
    tick(); check_a("lw_wb", 5, STB_WB, SEL_WB_L);
    tick(); check("lw_count", a_instr_count, 32'd2);
    check("lw_back_if", 32'(a_state), 32'd1);

    // ---- BEQ taken, BNE with zero=1 (not taken), BNE with zero=0 (taken) ----
    a_opcode = 6'd4; a_zero = 1'b1;
    tick(); tick(); check_a("beq_ex", 3, STB_BR_TK, SEL_BR);
    tick(); check("beq_count", a_instr_count, 32'd3);
    a_opcode = 6'd5;
    tick(); tick(); check_a("bne_z1_ex", 3, STB_BR_NT, SEL_BR);
    tick(); check("bne_z1_count", a_instr_count, 32'd4);
    a_zero = 1'b0;
    tick(); tick(); check_a("bne_z0_ex", 3, STB_BR_TK, SEL_BR);
    tick(); check("bne_z0_count", a_instr_count, 32'd5);

    // ---- R-type SLT ----
    a_opcode = 6'd0; a_funct = 6'd42;
    tick(); tick(); check_a("slt_ex", 3, STB_EX, SEL_SLT);
    tick(); check_a("slt_wb", 5, STB_WB, SEL_WB_R);
    tick(); check("slt_count", a_instr_count, 32'd6);

    // ---- J retires from ID ----
    a_opcode = 6'd2;
    tick(); check_a("j_id", 2, STB_ID_J, SEL_ID_J);
    tick(); check("j_count", a_instr_count, 32'd7);

    // ---- ORI ----
    a_opcode = 6'd13;
    tick(); tick(); check_a("ori_ex", 3, STB_EX, SEL_ORI);
    tick(); check_a("ori_wb", 5, STB_WB, SEL_ZERO);
    tick(); check("ori_count", a_instr_count, 32'd8);

    // ---- R-type with unknown funct traps into ERR ----
    a_opcode = 6'd0; a_funct = 6'd0;
    tick(); tick(); check_a("ill_ex", 3, STB_NONE, SEL_ZERO);
    tick(); check_a("ill_err", 7, STB_NONE, SEL_ZERO);
    check("ill_err_flag", 32'(a_err), 32'd1);
    tick(); check_a("ill_err_hold", 7, STB_NONE, SEL_ZERO);
    check("ill_count", a_instr_count, 32'd8);

    // ---- b: timeout after four stalled IF cycles ----
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); check_b($sformatf("to_if%0d", i), 1, STB_IF_WT, SEL_IF);
    end
    tick(); check_b("to_err", 7, STB_NONE, SEL_ZERO);
    check("to_err_flag", 32'(b_err), 32'd1);

    // ---- b: ready on the fourth cycle wins over timeout ----
    b_rst_n = 1'b0;
    #2 b_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_b($sformatf("rdy_if%0d", i), 1, STB_IF_WT, SEL_IF);
    end
    tick();
    b_mem_ready = 1'b1;
    #1 check_b("rdy_if3", 1, STB_IF_RDY, SEL_IF);
    tick(); check_b("rdy_id", 2, STB_ID_J, SEL_ID_J);
    check("rdy_no_err", 32'(b_err), 32'd0);

    // ---- b: five J instructions wrap the 2-bit counter ----
    tick(); check("j_wrap0", 32'(b_instr_count), 32'd1);
    j_exp[0] = 2'd2; j_exp[1] = 2'd3; j_exp[2] = 2'd0; j_exp[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      check($sformatf("j_wrap%0d", k + 1), 32'(b_instr_count), 32'(j_exp[k]));
    end

    // ---- b: illegal opcode and funct execute as NOP ----
    b_opcode = 6'd63;
    tick(); check_b("nop_id", 2, STB_ID_ILL, SEL_ID);
    tick(); check_b("nop_id_next", 1, STB_IF_RDY, SEL_IF);
    check("nop_id_count", 32'(b_instr_count), 32'd2);
    b_opcode = 6'd0; b_funct = 6'd0;
    tick(); tick(); check_b("nop_ex", 3, STB_BR_NT, SEL_ZERO);
    tick(); check("nop_ex_count", 32'(b_instr_count), 32'd3);

    // ---- b: reset asserted while SW waits in MEM ----
    b_opcode = 6'd43;
    tick(); tick();
    b_mem_ready = 1'b0;
    tick(); check_b("sw_mem", 4, STB_SW_WT, SEL_ZERO);
    b_rst_n = 1'b0;
    #1 check_b("sw_rst", 0, STB_NONE, SEL_ZERO);
    check("sw_rst_count", 32'(b_instr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
